aes_kexp_iter: RTL and testbench

AES_KEXP_ITER -- requirements
Module: aes_kexp_iter

---
 rtl/aes_kexp_iter_if.sv | 26 ++
 rtl/aes_kexp_iter.sv | 152 +++++++++++++++
 tb/tb_aes_kexp_iter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_kexp_iter_if.sv
// Bus bundle for the iterative AES key expander: request, key/S-box inputs,
// round-key read port and status outputs.
interface aes_kexp_iter_if #(
  parameter int MaxNk = 8
);
  logic         Start;
  logic [1:0]   KeyLen;
  logic [7:0]   Key [4*MaxNk];
  logic [7:0]   SBox [256];
  logic [3:0]   RdIdx;
  logic         Busy;
  logic         Done;
  logic         KeyValid;
  logic         Err;
  logic [127:0] RdKey;

  modport master (
    output Start, KeyLen, Key, SBox, RdIdx,
    input  Busy, Done, KeyValid, Err, RdKey
  );

  modport slave (
    input  Start, KeyLen, Key, SBox, RdIdx,
    output Busy, Done, KeyValid, Err, RdKey
  );
endinterface

// File: rtl/aes_kexp_iter.sv
// Iterative AES-128/192/256 key expansion: one schedule word per cycle
// through a single 4-byte S-box path, with a registered round-key read port.
module aes_kexp_iter #(
  parameter int MaxNk = 8
) (
  input logic            clock,
  input logic            reset,
  aes_kexp_iter_if.slave bus
);
  localparam int MaxNr = MaxNk + 6;
  localparam int MaxW  = 4 * (MaxNr + 1);
  localparam int AW    = $clog2(MaxW);
  localparam int KW    = $clog2(4 * MaxNk);
  localparam logic [3:0] MaxNkW = 4'(MaxNk);

  typedef enum logic {IDLE, EXPAND} state_e;

  state_e        state_q, state_d;
  logic [3:0]    nk_q, nk_d;
  logic [3:0]    nr_q, nr_d;
  logic [AW-1:0] i_q, i_d;
  logic [2:0]    j_q, j_d;
  logic [7:0]    rcon_q, rcon_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          kv_q, kv_d;
  logic [127:0]  rd_key_q, rd_key_d;
  logic [31:0]   w_q [MaxW];
  logic [31:0]   w_d [MaxW];

  logic [31:0]   prev_word, back_word, sub_in, sub_out, new_word;
  logic [3:0]    req_nk;
  logic          req_ok;
  logic [AW-1:0] last_idx, rd_base;

  // j_q tracks i mod Nk so the word-type decision needs no divider.
  always_comb begin
    prev_word = w_q[i_q - AW'(1)];
    back_word = w_q[i_q - AW'(nk_q)];
    sub_in    = (j_q == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
    sub_out   = {bus.SBox[sub_in[31:24]], bus.SBox[sub_in[23:16]],
                 bus.SBox[sub_in[15:8]],  bus.SBox[sub_in[7:0]]};
    if (j_q == 3'd0) begin
      new_word = back_word ^ sub_out ^ {rcon_q, 24'h0};
    end else if (nk_q == 4'd8 && j_q == 3'd4) begin
      new_word = back_word ^ sub_out;
    end else begin
      new_word = back_word ^ prev_word;
    end
    req_nk   = 4'd4 + {1'b0, bus.KeyLen, 1'b0};
    req_ok   = (bus.KeyLen != 2'd3) && (req_nk <= MaxNkW);
    last_idx = AW'({nr_q, 2'b00}) + AW'(3);
  end

  always_comb begin
    state_d = state_q;
    nk_d    = nk_q;
    nr_d    = nr_q;
    i_d     = i_q;
    j_d     = j_q;
    rcon_d  = rcon_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    kv_d    = kv_q;
    w_d     = w_q;
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          if (req_ok) begin
            nk_d    = req_nk;
            nr_d    = req_nk + 4'd6;
            i_d     = AW'(req_nk);
            j_d     = '0;
            rcon_d  = 8'h01;
            kv_d    = 1'b0;
            state_d = EXPAND;
            for (int unsigned k = 0; k < MaxNk; k++) begin
              if (k < 32'(req_nk)) begin
                w_d[AW'(k)] = {bus.Key[KW'(4*k)],   bus.Key[KW'(4*k+1)],
                               bus.Key[KW'(4*k+2)], bus.Key[KW'(4*k+3)]};
              end
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      EXPAND: begin
        w_d[i_q] = new_word;
        i_d      = i_q + AW'(1);
        j_d      = ({1'b0, j_q} == nk_q - 4'd1) ? 3'd0 : j_q + 3'd1;
        if (j_q == 3'd0) begin
          rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        end
        if (i_q == last_idx) begin
          done_d  = 1'b1;
          kv_d    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_base  = AW'({bus.RdIdx, 2'b00});
    rd_key_d = '0;
    if (kv_q && bus.RdIdx <= nr_q) begin
      rd_key_d = {w_q[rd_base],            w_q[rd_base + AW'(1)],
                  w_q[rd_base + AW'(2)],   w_q[rd_base + AW'(3)]};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      nk_q     <= 4'd4;
      nr_q     <= 4'd10;
      i_q      <= '0;
      j_q      <= '0;
      rcon_q   <= 8'h01;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      kv_q     <= 1'b0;
      rd_key_q <= '0;
    end else begin
      state_q  <= state_d;
      nk_q     <= nk_d;
      nr_q     <= nr_d;
      i_q      <= i_d;
      j_q      <= j_d;
      rcon_q   <= rcon_d;
      done_q   <= done_d;
      err_q    <= err_d;
      kv_q     <= kv_d;
      rd_key_q <= rd_key_d;
    end
  end

  // Schedule storage is not reset; KeyValid masks stale contents.
  always_ff @(posedge clock) begin
    if (!reset) begin
      w_q <= w_d;
    end
  end

  assign bus.Busy     = (state_q == EXPAND);
  assign bus.Done     = done_q;
  assign bus.Err      = err_q;
  assign bus.KeyValid = kv_q;
  assign bus.RdKey    = rd_key_q;
endmodule

// File: tb/tb_aes_kexp_iter.sv
// Self-checking bench for aes_kexp_iter: FIPS-197 vectors, randomized keys and
// S-boxes against a behavioural key-schedule model, error/ignore/reset cases.
module tb_aes_kexp_iter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  aes_kexp_iter_if #(.MaxNk(8)) bus ();
  aes_kexp_iter #(.MaxNk(8)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  logic [7:0]  sbox_m [256];
  logic [7:0]  key_b  [32];
  logic [31:0] mw     [60];

  localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R128 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] R192 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] R256 = 128'hfe4890d1e6188d0b046df344706c631e;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // AES S-box from its definition: multiplicative inverse then affine map.
  task automatic gen_sbox();
    logic [7:0] inv, x;
    for (int v = 0; v < 256; v++) begin
      x = 8'(v);
      inv = 8'h01;
      if (v == 0) inv = 8'h00;
      else for (int e = 0; e < 254; e++) inv = gmul(inv, x);
      sbox_m[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic apply_sbox();
    for (int v = 0; v < 256; v++) bus.SBox[v] = sbox_m[v];
  endtask

  task automatic load_key(input logic [255:0] k);
    for (int j = 0; j < 32; j++) begin
      key_b[j]   = k[255 - 8*j -: 8];
      bus.Key[j] = key_b[j];
    end
  endtask

  task automatic load_random_key();
    for (int j = 0; j < 32; j++) begin
      key_b[j]   = 8'($urandom);
      bus.Key[j] = key_b[j];
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbox_m[x[31:24]], sbox_m[x[23:16]], sbox_m[x[15:8]], sbox_m[x[7:0]]};
  endfunction

  // Textbook FIPS-197 KeyExpansion over the current key_b / sbox_m.
  task automatic model(input int nk);
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < nk; i++) mw[i] = {key_b[4*i], key_b[4*i+1], key_b[4*i+2], key_b[4*i+3]};
    rc = 8'h01;
    for (int i = nk; i < 4 * (nk + 7); i++) begin
      t = mw[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      mw[i] = mw[i-nk] ^ t;
    end
  endtask

  task automatic start_run(input logic [1:0] kl);
    @(negedge clock);
    bus.KeyLen = kl;
    bus.Start  = 1'b1;
    @(negedge clock);
    bus.Start  = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int busy_cnt, output bit timeout);
    cyc      = 0;
    busy_cnt = bus.Busy ? 1 : 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clock);
      cyc++;
      if (bus.Busy) busy_cnt++;
      if (bus.Done) break;
    end
    timeout = !bus.Done;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if ({bus.Busy, bus.Done, bus.Err, bus.KeyValid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got %b exp 0000", {bus.Busy, bus.Done, bus.Err, bus.KeyValid});
    end
    checks++;
    if (bus.RdKey !== 128'h0) begin
      errors++;
      $display("FAIL reset_rdkey got %h exp 0", bus.RdKey);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.RdKey !== 128'h0) begin
      errors++;
      $display("FAIL idle_rdkey got %h exp 0", bus.RdKey);
    end
  endtask

  task automatic test_vector(input string tag, input logic [1:0] kl, input logic [255:0] k,
                             input logic [127:0] last_exp);
    int cyc, bc, nk, nr, n_exp;
    bit to;
    logic [127:0] exp;
    nk = 4 + 2 * int'(kl);
    nr = nk + 6;
    n_exp = 4 * (nr + 1) - nk;
    load_key(k);
    model(nk);
    start_run(kl);
    wait_done(cyc, bc, to);
    checks++;
    if (to || cyc != n_exp) begin
      errors++;
      $display("FAIL %s latency got %0d exp %0d (timeout=%0d)", tag, cyc, n_exp, to);
    end
    checks++;
    if (bc != n_exp) begin
      errors++;
      $display("FAIL %s busy_cycles got %0d exp %0d", tag, bc, n_exp);
    end
    checks++;
    if (bus.KeyValid !== 1'b1) begin
      errors++;
      $display("FAIL %s keyvalid got %b exp 1", tag, bus.KeyValid);
    end
    bus.RdIdx = 4'(nr);
    @(negedge clock);
    checks++;
    if (bus.Done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse got %b exp 0", tag, bus.Done);
    end
    checks++;
    if (bus.RdKey !== last_exp) begin
      errors++;
      $display("FAIL %s last_round got %h exp %h", tag, bus.RdKey, last_exp);
    end
    bus.RdIdx = 4'd0;
    @(negedge clock);
    checks++;
    if (bus.RdKey !== k[255:128]) begin
      errors++;
      $display("FAIL %s round0 got %h exp %h", tag, bus.RdKey, k[255:128]);
    end
    for (int r = 0; r <= nr; r++) begin
      bus.RdIdx = 4'(r);
      @(negedge clock);
      exp = {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
      checks++;
      if (bus.RdKey !== exp) begin
        errors++;
        $display("FAIL %s model_round%0d got %h exp %h", tag, r, bus.RdKey, exp);
      end
    end
  endtask

  task automatic test_random();
    int cyc, bc, nk, nr, n_exp;
    bit to;
    logic [1:0] kl;
    logic [127:0] exp;
    for (int v = 0; v < 256; v++) sbox_m[v] = 8'($urandom);
    apply_sbox();
    for (int t = 0; t < 6; t++) begin
      kl = 2'(t % 3);
      nk = 4 + 2 * int'(kl);
      nr = nk + 6;
      n_exp = 4 * (nr + 1) - nk;
      load_random_key();
      model(nk);
      start_run(kl);
      wait_done(cyc, bc, to);
      checks++;
      if (to || cyc != n_exp) begin
        errors++;
        $display("FAIL rand%0d latency got %0d exp %0d", t, cyc, n_exp);
      end
      for (int r = 0; r <= nr; r++) begin
        bus.RdIdx = 4'(r);
        @(negedge clock);
        exp = {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
        checks++;
        if (bus.RdKey !== exp) begin
          errors++;
          $display("FAIL rand%0d round%0d got %h exp %h", t, r, bus.RdKey, exp);
        end
      end
    end
    gen_sbox();
    apply_sbox();
  endtask

  task automatic test_illegal();
    @(negedge clock);
    bus.KeyLen = 2'd3;
    bus.Start  = 1'b1;
    @(negedge clock);
    bus.Start  = 1'b0;
    checks++;
    if ({bus.Err, bus.Busy, bus.KeyValid} !== 3'b101) begin
      errors++;
      $display("FAIL illegal_first got err/busy/kv %b exp 101", {bus.Err, bus.Busy, bus.KeyValid});
    end
    bus.RdIdx = 4'd10;
    @(negedge clock);
    checks++;
    if ({bus.Err, bus.Busy, bus.KeyValid} !== 3'b001) begin
      errors++;
      $display("FAIL illegal_after got err/busy/kv %b exp 001", {bus.Err, bus.Busy, bus.KeyValid});
    end
    checks++;
    if (bus.RdKey !== R128) begin
      errors++;
      $display("FAIL illegal_storage got %h exp %h", bus.RdKey, R128);
    end
  endtask

  task automatic test_ignore_start();
    int cyc, bc;
    bit to;
    load_key({K128, 128'h0});
    start_run(2'd0);
    repeat (10) @(negedge clock);
    load_random_key();
    bus.KeyLen = 2'd2;
    bus.Start  = 1'b1;
    @(negedge clock);
    bus.Start  = 1'b0;
    checks++;
    if (bus.Err !== 1'b0 || bus.Busy !== 1'b1) begin
      errors++;
      $display("FAIL ignore_err got err %b busy %b exp 0 1", bus.Err, bus.Busy);
    end
    wait_done(cyc, bc, to);
    checks++;
    if (to || cyc != 29) begin
      errors++;
      $display("FAIL ignore_latency got %0d exp 29", cyc);
    end
    bus.RdIdx = 4'd10;
    @(negedge clock);
    checks++;
    if (bus.RdKey !== R128) begin
      errors++;
      $display("FAIL ignore_round10 got %h exp %h", bus.RdKey, R128);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, bc;
    bit to;
    load_key(K256);
    start_run(2'd2);
    repeat (19) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus.Busy, bus.KeyValid, bus.Done} !== 3'b000 || bus.RdKey !== 128'h0) begin
      errors++;
      $display("FAIL reset_mid got busy/kv/done %b rdkey %h exp 000 0",
               {bus.Busy, bus.KeyValid, bus.Done}, bus.RdKey);
    end
    @(negedge clock);
    reset = 1'b0;
    load_key({K128, 128'h0});
    start_run(2'd0);
    wait_done(cyc, bc, to);
    checks++;
    if (to || cyc != 40) begin
      errors++;
      $display("FAIL post_reset_latency got %0d exp 40", cyc);
    end
    bus.RdIdx = 4'd10;
    @(negedge clock);
    checks++;
    if (bus.RdKey !== R128) begin
      errors++;
      $display("FAIL post_reset_round10 got %h exp %h", bus.RdKey, R128);
    end
  endtask

  task automatic test_rdidx_range();
    bus.RdIdx = 4'd11;
    @(negedge clock);
    checks++;
    if (bus.RdKey !== 128'h0) begin
      errors++;
      $display("FAIL rdidx11 got %h exp 0", bus.RdKey);
    end
    bus.RdIdx = 4'd15;
    @(negedge clock);
    checks++;
    if (bus.RdKey !== 128'h0) begin
      errors++;
      $display("FAIL rdidx15 got %h exp 0", bus.RdKey);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, bc;
    bit to;
    logic [127:0] exp;
    load_key({K192, 64'h0});
    start_run(2'd1);
    wait_done(cyc, bc, to);
    checks++;
    if (to || cyc != 46) begin
      errors++;
      $display("FAIL b2b_first_latency got %0d exp 46", cyc);
    end
    load_random_key();
    model(4);
    bus.KeyLen = 2'd0;
    bus.Start  = 1'b1;
    bus.RdIdx  = 4'd12;
    @(negedge clock);
    bus.Start  = 1'b0;
    checks++;
    if (bus.RdKey !== R192 || bus.Busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_round12 got %h busy %b exp %h 1", bus.RdKey, bus.Busy, R192);
    end
    wait_done(cyc, bc, to);
    checks++;
    if (to || cyc != 40) begin
      errors++;
      $display("FAIL b2b_second_latency got %0d exp 40", cyc);
    end
    for (int r = 0; r <= 10; r++) begin
      bus.RdIdx = 4'(r);
      @(negedge clock);
      exp = {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
      checks++;
      if (bus.RdKey !== exp) begin
        errors++;
        $display("FAIL b2b_round%0d got %h exp %h", r, bus.RdKey, exp);
      end
    end
  endtask

  initial begin
    bus.Start  = 1'b0;
    bus.KeyLen = 2'd0;
    bus.RdIdx  = 4'd0;
    for (int j = 0; j < 32; j++) bus.Key[j] = 8'h00;
    gen_sbox();
    apply_sbox();
    test_reset();
    test_vector("aes128", 2'd0, {K128, 128'h0}, R128);
    test_illegal();
    test_vector("aes192", 2'd1, {K192, 64'h0}, R192);
    test_vector("aes256", 2'd2, K256, R256);
    test_random();
    test_ignore_start();
    test_reset_mid();
    test_rdidx_range();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
